// File: rtl/spi_pkg.sv
// Types and constants shared by the SPI slave receiver and transmitter.
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 8;
    localparam logic [SPI_WORD_W-1:0] SPI_FILL = 8'hFF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus history flop with rise/fall detection on the last two stages.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [2:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {3{RST_VAL}};
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_rise_c = r_sync[1] & ~r_sync[2];
    assign o_fall_c = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: oversamples SCK/SSEL in the clk domain and shifts words out MSB first.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WORD_W,
    parameter logic [WIDTH-1:0] FILL = SPI_FILL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCK,
    input  logic             SSEL,
    output logic             MISO,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             word_done,
    output logic             underrun,
    output logic             aborted
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic w_sck_rise, w_sck_fall, w_ssel_rise, w_ssel_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (SCK),
        .o_rise_c (w_sck_rise),
        .o_fall_c (w_sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ssel_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (SSEL),
        .o_rise_c (w_ssel_rise),
        .o_fall_c (w_ssel_fall)
    );

    spi_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic             r_reload, w_reload_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [WIDTH-1:0] r_hold, w_hold_nxt;
    logic             r_hold_empty, w_hold_empty_nxt;
    logic             r_miso, w_miso_nxt;
    logic             r_oe, w_oe_nxt;
    logic             r_word_done, w_word_done_nxt;
    logic             r_underrun, w_underrun_nxt;
    logic             r_aborted, w_aborted_nxt;
    logic             w_load;

    // Next-state, datapath and pulse generation
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_reload_nxt     = r_reload;
        w_shift_nxt      = r_shift;
        w_hold_nxt       = r_hold;
        w_hold_empty_nxt = r_hold_empty;
        w_word_done_nxt  = 1'b0;
        w_underrun_nxt   = 1'b0;
        w_aborted_nxt    = 1'b0;
        w_load           = 1'b0;

        case (r_state)
            IDLE: begin
                // SCK edges coinciding with the select edge are dropped here
                if (w_ssel_fall) begin
                    w_load        = 1'b1;
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_reload_nxt  = 1'b0;
                end
            end
            SHIFT: begin
                if (w_ssel_rise) begin
                    w_aborted_nxt = (r_bit_cnt != '0);
                    w_state_nxt   = IDLE;
                    w_bit_cnt_nxt = '0;
                    w_reload_nxt  = 1'b0;
                end else if (w_sck_rise) begin
                    if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                        w_word_done_nxt = 1'b1;
                        w_bit_cnt_nxt   = '0;
                        w_reload_nxt    = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end else if (w_sck_fall) begin
                    if (r_reload) begin
                        w_load       = 1'b1;
                        w_reload_nxt = 1'b0;
                    end else if (r_bit_cnt != '0) begin
                        w_shift_nxt = {r_shift[WIDTH-2:0], 1'b1};
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_load) begin
            if (!r_hold_empty) begin
                w_shift_nxt      = r_hold;
                w_hold_empty_nxt = 1'b1;
            end else begin
                w_shift_nxt    = FILL;
                w_underrun_nxt = 1'b1;
            end
        end

        // An empty holding register may accept in the same cycle an underrun load occurs
        if (tx_valid && r_hold_empty) begin
            w_hold_nxt       = tx_data;
            w_hold_empty_nxt = 1'b0;
        end

        w_oe_nxt   = (w_state_nxt == SHIFT);
        w_miso_nxt = (w_state_nxt == SHIFT) ? w_shift_nxt[WIDTH-1] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_reload     <= 1'b0;
            r_shift      <= FILL;
            r_hold       <= '0;
            r_hold_empty <= 1'b1;
            r_miso       <= 1'b1;
            r_oe         <= 1'b0;
            r_word_done  <= 1'b0;
            r_underrun   <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_reload     <= w_reload_nxt;
            r_shift      <= w_shift_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_empty <= w_hold_empty_nxt;
            r_miso       <= w_miso_nxt;
            r_oe         <= w_oe_nxt;
            r_word_done  <= w_word_done_nxt;
            r_underrun   <= w_underrun_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

    assign MISO      = r_miso;
    assign miso_oe   = r_oe;
    assign tx_ready  = r_hold_empty;
    assign word_done = r_word_done;
    assign underrun  = r_underrun;
    assign aborted   = r_aborted;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed testbench for spi_slave_tx acting as a mode-0 SPI master.
module tb_spi_slave_tx;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCK = 1'b0;
    logic       SSEL = 1'b1;
    logic       MISO, miso_oe, tx_ready, word_done, underrun, aborted;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cnt_wd = 0;
    int cnt_ur = 0;
    int cnt_ab = 0;

    always #5 clk = ~clk;

    spi_slave_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCK       (SCK),
        .SSEL      (SSEL),
        .MISO      (MISO),
        .miso_oe   (miso_oe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .word_done (word_done),
        .underrun  (underrun),
        .aborted   (aborted)
    );

    always @(negedge clk) begin
        if (word_done) cnt_wd++;
        if (underrun)  cnt_ur++;
        if (aborted)   cnt_ab++;
    end

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic sel();
        @(negedge clk);
        SSEL = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic desel();
        @(negedge clk);
        SSEL = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Runs n full SCK cycles; snapshots pulse counts before the trailing falling edge
    task automatic xfer(input int n, output logic [15:0] data, output int wd_pre,
                        output int ur_pre, output int oe_bad);
        data = '0;
        oe_bad = 0;
        wd_pre = 0;
        ur_pre = 0;
        for (int i = 0; i < n; i++) begin
            repeat (HALF) @(negedge clk);
            data = {data[14:0], MISO};
            if (miso_oe !== 1'b1) oe_bad++;
            SCK = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i == n - 1) begin
                wd_pre = cnt_wd;
                ur_pre = cnt_ur;
            end
            SCK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_ready, MISO, miso_oe, word_done, underrun, aborted} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 110000",
                     {tx_ready, MISO, miso_oe, word_done, underrun, aborted});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        logic [15:0] d;
        int wd0, ur0, wdp, urp, oeb;
        push(8'hA5);
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_ready_low: got %b want 0", tx_ready);
        end
        wd0 = cnt_wd; ur0 = cnt_ur;
        sel();
        xfer(8, d, wdp, urp, oeb);
        desel();
        n_checks++;
        if (d[7:0] !== 8'hA5) begin
            n_fail++; $display("FAIL single_data: got %h want a5", d[7:0]);
        end
        n_checks++;
        if (wdp - wd0 != 1) begin
            n_fail++; $display("FAIL single_word_done: got %0d want 1", wdp - wd0);
        end
        n_checks++;
        if (urp - ur0 != 0) begin
            n_fail++; $display("FAIL single_underrun: got %0d want 0", urp - ur0);
        end
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready_back: got %b want 1", tx_ready);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] d;
        int ur0, wdp, urp, oeb;
        ur0 = cnt_ur;
        sel();
        xfer(8, d, wdp, urp, oeb);
        desel();
        n_checks++;
        if (d[7:0] !== 8'hFF) begin
            n_fail++; $display("FAIL underrun_data: got %h want ff", d[7:0]);
        end
        n_checks++;
        if (urp - ur0 != 1) begin
            n_fail++; $display("FAIL underrun_pulses: got %0d want 1", urp - ur0);
        end
        n_checks++;
        if (oeb != 0) begin
            n_fail++; $display("FAIL underrun_oe: got %0d low samples want 0", oeb);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        int wd0, ur0, wdp, urp, oeb, guard;
        push(8'h3C);
        wd0 = cnt_wd; ur0 = cnt_ur;
        sel();
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_timeout: got %b want 1", tx_ready);
        end
        push(8'hC3);
        xfer(16, d, wdp, urp, oeb);
        desel();
        n_checks++;
        if (d !== 16'h3CC3) begin
            n_fail++; $display("FAIL b2b_data: got %h want 3cc3", d);
        end
        n_checks++;
        if (wdp - wd0 != 2) begin
            n_fail++; $display("FAIL b2b_word_done: got %0d want 2", wdp - wd0);
        end
        n_checks++;
        if (urp - ur0 != 0) begin
            n_fail++; $display("FAIL b2b_underrun: got %0d want 0", urp - ur0);
        end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        int ab0, wdp, urp, oeb;
        push(8'h81);
        ab0 = cnt_ab;
        sel();
        xfer(3, d, wdp, urp, oeb);
        desel();
        n_checks++;
        if (d[2:0] !== 3'b100) begin
            n_fail++; $display("FAIL abort_partial: got %b want 100", d[2:0]);
        end
        n_checks++;
        if (cnt_ab - ab0 != 1) begin
            n_fail++; $display("FAIL abort_pulse: got %0d want 1", cnt_ab - ab0);
        end
        n_checks++;
        if ({MISO, miso_oe} !== 2'b10) begin
            n_fail++; $display("FAIL abort_idle_pins: got %b want 10", {MISO, miso_oe});
        end
        push(8'h5A);
        sel();
        xfer(8, d, wdp, urp, oeb);
        desel();
        n_checks++;
        if (d[7:0] !== 8'h5A) begin
            n_fail++; $display("FAIL abort_next_word: got %h want 5a", d[7:0]);
        end
        n_checks++;
        if (cnt_ab - ab0 != 1) begin
            n_fail++; $display("FAIL abort_clean_end: got %0d want 1", cnt_ab - ab0);
        end
    endtask

    task automatic test_reset_midword();
        logic [15:0] d;
        int wdp, urp, oeb;
        push(8'h11);
        sel();
        push(8'h22);
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_hold_full: got %b want 0", tx_ready);
        end
        xfer(3, d, wdp, urp, oeb);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tx_ready, miso_oe, MISO, word_done, underrun, aborted} !== 6'b101000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %b want 101000",
                     {tx_ready, miso_oe, MISO, word_done, underrun, aborted});
        end
        rst_n = 1'b1;
        SSEL  = 1'b1;
        repeat (HALF) @(negedge clk);
        sel();
        xfer(8, d, wdp, urp, oeb);
        desel();
        n_checks++;
        if (d[7:0] !== 8'hFF) begin
            n_fail++; $display("FAIL rstmid_hold_lost: got %h want ff", d[7:0]);
        end
    endtask

    task automatic test_sck_deselected();
        logic [15:0] d;
        int wd0, bad, wdp, urp, oeb;
        push(8'h96);
        wd0 = cnt_wd;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            repeat (HALF) @(negedge clk);
            SCK = ~SCK;
            if ({MISO, miso_oe} !== 2'b10) bad++;
        end
        SCK = 1'b0;
        repeat (HALF) @(negedge clk);
        n_checks++;
        if (bad != 0 || {MISO, miso_oe} !== 2'b10) begin
            n_fail++; $display("FAIL desel_pins: got %0d bad samples, pins %b want 10", bad, {MISO, miso_oe});
        end
        n_checks++;
        if (cnt_wd - wd0 != 0) begin
            n_fail++; $display("FAIL desel_word_done: got %0d want 0", cnt_wd - wd0);
        end
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fail++; $display("FAIL desel_hold_kept: got %b want 0", tx_ready);
        end
        sel();
        xfer(8, d, wdp, urp, oeb);
        desel();
        n_checks++;
        if (d[7:0] !== 8'h96) begin
            n_fail++; $display("FAIL desel_data: got %h want 96", d[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_midword();
        test_sck_deselected();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
